// File: rtl/pc_fetch.sv
// Instruction fetch front end: single-outstanding request FSM with drop-on-flush,
// presents one instruction at a time downstream and counts accepted instructions.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter bit          FLUSH_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_drop, w_drop_nxt;
  logic        r_if_valid, w_if_valid_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic [31:0] r_if_instr, w_if_instr_nxt;
  logic [31:0] r_fetch_cnt, w_fetch_cnt_nxt;
  logic        w_flush;

  assign w_flush = FLUSH_EN && flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC & PC_MASK;
      r_drop      <= 1'b0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= 32'h0;
      r_if_instr  <= 32'h0;
      r_fetch_cnt <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drop      <= w_drop_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_if_pc     <= w_if_pc_nxt;
      r_if_instr  <= w_if_instr_nxt;
      r_fetch_cnt <= w_fetch_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_drop_nxt      = r_drop;
    w_if_valid_nxt  = r_if_valid;
    w_if_pc_nxt     = r_if_pc;
    w_if_instr_nxt  = r_if_instr;
    w_fetch_cnt_nxt = r_fetch_cnt;
    case (r_state)
      S_REQ: begin
        if (w_flush) begin
          w_pc_nxt = flush_pc & PC_MASK;
          // A grant in the flush cycle still leaves a response in flight.
          if (imem_gnt) begin
            w_drop_nxt  = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end else if (imem_gnt) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_flush) begin
          w_pc_nxt = flush_pc & PC_MASK;
          // Response landing in the flush cycle completes the old request.
          if (imem_rvalid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_if_instr_nxt = imem_rdata;
            w_if_pc_nxt    = r_pc;
            w_if_valid_nxt = 1'b1;
            w_state_nxt    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_flush) begin
          w_pc_nxt       = flush_pc & PC_MASK;
          w_if_valid_nxt = 1'b0;
          w_state_nxt    = S_REQ;
        end else if (r_if_valid && if_ready) begin
          w_pc_nxt        = npc & PC_MASK;
          w_if_valid_nxt  = 1'b0;
          w_fetch_cnt_nxt = r_fetch_cnt + 32'd1;
          w_state_nxt     = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  assign imem_req  = rst_n && (r_state == S_REQ);
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch: the bench plays the instruction memory and
// checks every cycle against a transaction-level model of the fetch rules.
module tb_pc_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic [31:0] fetch_cnt;

  pc_fetch #(.RESET_PC(RESET_PC), .FLUSH_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .npc(npc), .flush(flush), .flush_pc(flush_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_ready(if_ready), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: program counter, instruction count, and whether a fetch is in flight,
  // was abandoned by a flush, or is being presented downstream.
  logic [31:0] m_pc, m_cnt, m_out_addr;
  logic        m_out, m_stale, m_pres;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h2008_3005;
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_cnt = 0; m_out_addr = 0;
    m_out = 0; m_stale = 0; m_pres = 0;
  endtask

  task automatic drive_idle();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    if_ready = 0; flush = 0; flush_pc = 0; npc = 0;
  endtask

  // One clock cycle: check at negedge, drive inputs, advance model at posedge.
  task automatic cycle(input logic g, input logic r, input logic rdy,
                       input logic fl, input logic [31:0] fpc, input logic [31:0] npcv);
    logic exp_req, ng;
    @(negedge clk);
    exp_req = !m_out && !m_pres;
    chk_val("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk_val("imem_addr", imem_addr, m_pc);
    chk_val("if_valid", {31'b0, if_valid}, {31'b0, m_pres});
    if (m_pres) begin
      chk_val("if_pc", if_pc, m_pc);
      chk_val("if_instr", if_instr, mem_word(m_pc));
    end
    chk_val("fetch_cnt", fetch_cnt, m_cnt);
    imem_gnt    = g;
    imem_rvalid = r;
    imem_rdata  = m_out ? mem_word(m_out_addr) : $urandom;
    if_ready    = rdy;
    flush       = fl;
    flush_pc    = fpc;
    npc         = npcv;
    @(posedge clk);
    ng = exp_req && g;
    if (fl) begin
      if (ng) begin m_out = 1; m_out_addr = m_pc; m_stale = 1; end
      else if (m_out && r) begin m_out = 0; m_stale = 0; end
      else if (m_out) m_stale = 1;
      m_pres = 0;
      m_pc = fpc & 32'hFFFF_FFFC;
    end else begin
      if (ng) begin m_out = 1; m_out_addr = m_pc; end
      else if (m_out && r) begin
        m_out = 0;
        if (m_stale) m_stale = 0; else m_pres = 1;
      end else if (m_pres && rdy) begin
        m_pres = 0; m_cnt++; m_pc = npcv & 32'hFFFF_FFFC;
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    drive_idle();
    #2 rst_n = 0;
    #1;
    chk_val("rst_req", {31'b0, imem_req}, 32'h0);
    chk_val("rst_valid", {31'b0, if_valid}, 32'h0);
    chk_val("rst_addr", imem_addr, RESET_PC);
    chk_val("rst_cnt", fetch_cnt, 32'h0);
    chk_val("rst_ifpc", if_pc, 32'h0);
    chk_val("rst_instr", if_instr, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk_val("rst_hold_req", {31'b0, imem_req}, 32'h0);
    end
    rst_n = 1;
    #1;
    chk_val("first_addr", imem_addr, 32'h0000_3000);
    chk_val("first_req", {31'b0, imem_req}, 32'h1);

    // First fetch with immediate grant and response.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    #1;
    chk_val("d_instr", if_instr, 32'h2008_0005);
    chk_val("d_ifpc", if_pc, 32'h0000_3000);
    cycle(0, 0, 1, 0, 0, m_pc + 4);
    #1 chk_val("d_cnt1", fetch_cnt, 32'd1);

    // Sequential run.
    repeat (3) begin
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, m_pc + 4);
    end
    #1;
    chk_val("seq_cnt", fetch_cnt, 32'd4);
    chk_val("seq_addr", imem_addr, 32'h0000_3010);

    // Back-pressure in HOLD with stray grants.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    repeat (5) cycle(1, 1, 0, 0, 0, 32'hDEAD_BEEF);
    cycle(0, 0, 1, 0, 0, m_pc + 4);

    // Flush while waiting; stale response must be dropped.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h0040_0000, 0);
    cycle(0, 1, 0, 0, 0, 0);
    #1;
    chk_val("flush_addr", imem_addr, 32'h0040_0000);
    chk_val("flush_valid", {31'b0, if_valid}, 32'h0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);

    // Flush and handshake together in HOLD.
    cycle(0, 0, 1, 1, 32'h0050_0003, 32'h1234_0000);
    #1;
    chk_val("fh_cnt", fetch_cnt, 32'd5);
    chk_val("fh_addr", imem_addr, 32'h0050_0000);

    // Reset mid-transaction, then a late response is ignored.
    cycle(1, 0, 0, 0, 0, 0);
    reset_pulse();
    cycle(0, 1, 0, 0, 0, 0);
    #1 chk_val("refetch_addr", imem_addr, 32'h0000_3000);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] nv;
      nv = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 4;
      if ($urandom_range(0, 599) == 0) reset_pulse();
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 11) == 0, $urandom, nv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the first fetch address after reset.
REQ-002 Parameter FLUSH_EN, default 1, enables the flush port; when 0, flush is ignored.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 npc  input  32  next PC from the next-PC logic, computed from if_pc and if_instr.
REQ-006 flush  input  1  redirect request; the block abandons the current fetch.
REQ-007 flush_pc  input  32  redirect target, sampled when flush=1.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  32  request address, equal to the PC register.
REQ-010 imem_gnt  input  1  memory accepts the request in this cycle.
REQ-011 imem_rvalid  input  1  read data valid.
REQ-012 imem_rdata  input  32  read data (instruction).
REQ-013 if_valid  output  1  if_pc and if_instr hold a fetched instruction.
REQ-014 if_pc  output  32  address of the presented instruction.
REQ-015 if_instr  output  32  presented instruction word.
REQ-016 if_ready  input  1  downstream accepts the instruction this cycle.
REQ-017 fetch_cnt  output  32  count of instructions accepted downstream; wraps modulo 2^32.

Function
REQ-018 FSM states are REQ, WAIT and HOLD; at most one memory request is outstanding at any time.
REQ-019 In REQ: imem_req=1 and imem_addr=pc; imem_gnt=1 moves the FSM to WAIT; the address is stable until granted.
REQ-020 In WAIT: imem_req=0; imem_rvalid=1 captures if_instr<=imem_rdata and if_pc<=pc, sets if_valid=1, and moves the FSM to HOLD.
REQ-021 In HOLD: if_valid=1 and the outputs hold steady; on if_valid&&if_ready: pc<=npc, if_valid<=0, fetch_cnt+=1, and the FSM moves to REQ.
REQ-022 Fetch latency: a request is issued in the cycle after the handshake; minimum handshake-to-next-if_valid is 3 cycles with gnt and rvalid each arriving in the cycle after issue.
REQ-023 pc bits [1:0] are always 0; npc[1:0] and flush_pc[1:0] are forced to 0 when loaded.
REQ-024 Flush (FLUSH_EN=1) takes priority over every other event in the same cycle: pc<=flush_pc and if_valid<=0, with no fetch_cnt increment even if if_ready=1.
REQ-025 Flush in REQ: the FSM stays in REQ with the new address next cycle; a grant in the flush cycle counts as an outstanding request and is handled as in REQ-026.
REQ-026 Flush with a request outstanding: set drop flag and go to WAIT; the next imem_rvalid is discarded, clears drop, and the FSM moves to REQ.
REQ-027 Flush in HOLD: the FSM moves to REQ next cycle.
REQ-028 imem_rvalid outside WAIT is ignored.
REQ-029 imem_gnt outside REQ is ignored.

Reset
REQ-030 On rst_n=0 the block immediately enters REQ and sets pc=RESET_PC, if_valid=0, if_pc=0, if_instr=0, fetch_cnt=0, drop=0.
REQ-031 While rst_n=0, imem_req=0.
REQ-032 imem_req may rise in the first clock edge cycle after reset release.
REQ-033 Reset asserted mid-transaction abandons the transaction; a response arriving after reset release while the FSM is in REQ is ignored.

Verification
REQ-034 Reset release, gnt and rvalid each one cycle after request, rdata=32'h2008_0005, if_ready=1 -> imem_addr=0x3000; if_valid with if_pc=0x3000; fetch_cnt=1.
REQ-035 Sequential run with npc=if_pc+4, 4 instructions -> addresses 0x3000, 0x3004, 0x3008, 0x300C in order; fetch_cnt=4.
REQ-036 if_ready low 5 cycles in HOLD -> if_pc and if_instr stable, imem_req=0, no new request until the handshake.
REQ-037 Flush with flush_pc=0x0040_0000 while in WAIT, stale rvalid then arrives -> stale data never presented; next imem_addr=0x0040_0000.
REQ-038 Flush and if_ready both high in HOLD -> fetch_cnt unchanged; next address = flush_pc, not npc.
REQ-039 rst_n pulsed low while in WAIT -> outputs return to reset values asynchronously; refetch starts at 0x3000.
